// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq
// Description : Handshaked sequential ALU. Single-cycle ops (ADD..SRA, SLT,
//               SLTU) produce a registered result one cycle after accept.
//               MUL/DIVU/REMU run an iterative engine, one bit per cycle.
//               The result and the z/n/c/v flags are held stable until the
//               consumer takes them.
// Ports       : clk, rst_n                - clock, async active-low reset
//               in_valid/in_ready         - operand/op handshake
//               op1, op2, alu_control     - operands and op select
//               out_valid/out_ready       - result handshake
//               alu_out, flag_z/n/c/v     - result and status flags
// Revision    : 1.0 - initial release
// ============================================================================
module alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic [3:0]       alu_control,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_out,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_c,
    output logic             flag_v
);

    localparam int SHW = $clog2(WIDTH);

    localparam logic [3:0] c_op_add  = 4'b0000;
    localparam logic [3:0] c_op_sub  = 4'b0001;
    localparam logic [3:0] c_op_and  = 4'b0010;
    localparam logic [3:0] c_op_or   = 4'b0011;
    localparam logic [3:0] c_op_xor  = 4'b0100;
    localparam logic [3:0] c_op_xnor = 4'b0101;
    localparam logic [3:0] c_op_nand = 4'b0110;
    localparam logic [3:0] c_op_nor  = 4'b0111;
    localparam logic [3:0] c_op_sll  = 4'b1000;
    localparam logic [3:0] c_op_srl  = 4'b1001;
    localparam logic [3:0] c_op_sra  = 4'b1010;
    localparam logic [3:0] c_op_mul  = 4'b1011;
    localparam logic [3:0] c_op_divu = 4'b1100;
    localparam logic [3:0] c_op_remu = 4'b1101;
    localparam logic [3:0] c_op_slt  = 4'b1110;
    localparam logic [3:0] c_op_sltu = 4'b1111;

    localparam logic [SHW-1:0] c_last_count = SHW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [SHW-1:0]   r_count;
    logic [3:0]       r_op;
    // Engine registers. MUL: acc = partial product, x = shifted multiplicand,
    // y = shifted multiplier. DIVU/REMU: acc = partial remainder,
    // x = dividend shifting out / quotient shifting in, y = divisor.
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_x;
    logic [WIDTH-1:0] r_y;
    logic [WIDTH-1:0] r_alu_out;
    logic             r_z, r_n, r_c, r_v;

    logic             w_accept;
    logic             w_multi;
    logic             w_last;
    logic [SHW-1:0]   w_shamt;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_res;
    logic             w_c;
    logic             w_v;
    logic [WIDTH-1:0] w_mul_acc;
    logic [WIDTH:0]   w_div_trial;
    logic             w_div_ok;
    logic [WIDTH-1:0] w_div_rem;
    logic [WIDTH-1:0] w_div_quo;
    logic [WIDTH-1:0] w_iter_res;

    assign in_ready  = (r_state == IDLE) || ((r_state == DONE) && out_ready);
    assign w_accept  = in_valid && in_ready;
    assign w_multi   = (alu_control == c_op_mul) || (alu_control == c_op_divu) ||
                       (alu_control == c_op_remu);
    assign w_last    = (r_count == c_last_count);
    assign out_valid = (r_state == DONE);
    assign alu_out   = r_alu_out;
    assign flag_z    = r_z;
    assign flag_n    = r_n;
    assign flag_c    = r_c;
    assign flag_v    = r_v;

    // ------------------------------------------------------------------
    // Single-cycle datapath
    // ------------------------------------------------------------------
    assign w_shamt = op2[SHW-1:0];
    assign w_sum   = {1'b0, op1} + {1'b0, op2};
    // Top bit of the widened difference is the unsigned borrow.
    assign w_diff  = {1'b0, op1} - {1'b0, op2};

    always_comb begin
        w_res = '0;
        w_c   = 1'b0;
        w_v   = 1'b0;
        case (alu_control)
            c_op_add: begin
                w_res = w_sum[WIDTH-1:0];
                w_c   = w_sum[WIDTH];
                w_v   = (op1[WIDTH-1] == op2[WIDTH-1]) &&
                        (w_sum[WIDTH-1] != op1[WIDTH-1]);
            end
            c_op_sub: begin
                w_res = w_diff[WIDTH-1:0];
                w_c   = w_diff[WIDTH];
                w_v   = (op1[WIDTH-1] != op2[WIDTH-1]) &&
                        (w_diff[WIDTH-1] != op1[WIDTH-1]);
            end
            c_op_and:  w_res = op1 & op2;
            c_op_or:   w_res = op1 | op2;
            c_op_xor:  w_res = op1 ^ op2;
            c_op_xnor: w_res = ~(op1 ^ op2);
            c_op_nand: w_res = ~(op1 & op2);
            c_op_nor:  w_res = ~(op1 | op2);
            c_op_sll:  w_res = op1 << w_shamt;
            c_op_srl:  w_res = op1 >> w_shamt;
            c_op_sra:  w_res = WIDTH'($signed(op1) >>> w_shamt);
            c_op_slt:  w_res = {{(WIDTH-1){1'b0}}, ($signed(op1) < $signed(op2))};
            c_op_sltu: w_res = {{(WIDTH-1){1'b0}}, (op1 < op2)};
            default:   w_res = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Iterative engine: one step per BUSY cycle
    // ------------------------------------------------------------------
    assign w_mul_acc   = r_y[0] ? (r_acc + r_x) : r_acc;
    // Partial remainder is always below the divisor, so the trial
    // difference fits WIDTH bits when non-negative and its top bit is a
    // clean borrow otherwise. A zero divisor naturally yields an all-ones
    // quotient and a remainder equal to the dividend.
    assign w_div_trial = {r_acc, r_x[WIDTH-1]} - {1'b0, r_y};
    assign w_div_ok    = !w_div_trial[WIDTH];
    assign w_div_rem   = w_div_ok ? w_div_trial[WIDTH-1:0]
                                  : {r_acc[WIDTH-2:0], r_x[WIDTH-1]};
    assign w_div_quo   = {r_x[WIDTH-2:0], w_div_ok};

    always_comb begin
        w_iter_res = w_div_quo;
        if (r_op == c_op_mul) begin
            w_iter_res = w_mul_acc;
        end else if (r_op == c_op_remu) begin
            w_iter_res = w_div_rem;
        end
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_accept) begin
            w_state_nxt = w_multi ? BUSY : DONE;
        end else begin
            case (r_state)
                BUSY:    if (w_last) w_state_nxt = DONE;
                DONE:    if (out_ready) w_state_nxt = IDLE;
                default: w_state_nxt = r_state;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count   <= '0;
            r_op      <= '0;
            r_acc     <= '0;
            r_x       <= '0;
            r_y       <= '0;
            r_alu_out <= '0;
            r_z       <= 1'b0;
            r_n       <= 1'b0;
            r_c       <= 1'b0;
            r_v       <= 1'b0;
        end else if (w_accept) begin
            r_op    <= alu_control;
            r_count <= '0;
            if (w_multi) begin
                r_acc <= '0;
                r_x   <= op1;
                r_y   <= op2;
            end else begin
                r_alu_out <= w_res;
                r_z       <= (w_res == '0);
                r_n       <= w_res[WIDTH-1];
                r_c       <= w_c;
                r_v       <= w_v;
            end
        end else if (r_state == BUSY) begin
            r_count <= r_count + SHW'(1);
            if (r_op == c_op_mul) begin
                r_acc <= w_mul_acc;
                r_x   <= r_x << 1;
                r_y   <= r_y >> 1;
            end else begin
                r_acc <= w_div_rem;
                r_x   <= w_div_quo;
            end
            if (w_last) begin
                r_alu_out <= w_iter_res;
                r_z       <= (w_iter_res == '0);
                r_n       <= w_iter_res[WIDTH-1];
                r_c       <= 1'b0;
                r_v       <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_seq
// Description : Directed self-checking bench for alu_seq (WIDTH=32).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_seq;

    localparam int W = 32;

    localparam logic [3:0] c_add  = 4'b0000;
    localparam logic [3:0] c_sub  = 4'b0001;
    localparam logic [3:0] c_and  = 4'b0010;
    localparam logic [3:0] c_xnor = 4'b0101;
    localparam logic [3:0] c_nor  = 4'b0111;
    localparam logic [3:0] c_sll  = 4'b1000;
    localparam logic [3:0] c_srl  = 4'b1001;
    localparam logic [3:0] c_sra  = 4'b1010;
    localparam logic [3:0] c_mul  = 4'b1011;
    localparam logic [3:0] c_divu = 4'b1100;
    localparam logic [3:0] c_remu = 4'b1101;
    localparam logic [3:0] c_slt  = 4'b1110;
    localparam logic [3:0] c_sltu = 4'b1111;

    typedef struct packed {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic [3:0]   fl;   // {z, n, c, v}
        logic [7:0]   lat;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] op1 = '0;
    logic [W-1:0] op2 = '0;
    logic [3:0]   alu_control = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] alu_out;
    logic         flag_z, flag_n, flag_c, flag_v;

    int n_checks = 0;
    int n_fail   = 0;

    alu_seq #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .op1         (op1),
        .op2         (op2),
        .alu_control (alu_control),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .alu_out     (alu_out),
        .flag_z      (flag_z),
        .flag_n      (flag_n),
        .flag_c      (flag_c),
        .flag_v      (flag_v)
    );

    always #5 clk = ~clk;

    // Present one op, let it be accepted, scramble the inputs, and wait
    // (bounded) for out_valid. lat = clock edges from accept to out_valid.
    task automatic do_op(input logic [3:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, output int lat);
        @(negedge clk);
        alu_control = op;
        op1         = a;
        op2         = b;
        in_valid    = 1'b1;
        out_ready   = 1'b0;
        @(posedge clk);
        #1;
        in_valid    = 1'b0;
        op1         = 32'hDEAD_BEEF;
        op2         = 32'h0BAD_F00D;
        alu_control = 4'h0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic consume();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic run_table(input string name, input vec_t v[], input int n);
        int lat;
        for (int i = 0; i < n; i++) begin
            do_op(v[i].op, v[i].a, v[i].b, lat);
            n_checks++;
            if ({alu_out, flag_z, flag_n, flag_c, flag_v} !== {v[i].res, v[i].fl} ||
                lat != int'(v[i].lat)) begin
                n_fail++;
                $display("FAIL %s[%0d] op=%b: got res=%h zncv=%b lat=%0d, want res=%h zncv=%b lat=%0d",
                         name, i, v[i].op, alu_out, {flag_z, flag_n, flag_c, flag_v}, lat,
                         v[i].res, v[i].fl, v[i].lat);
            end
            consume();
        end
    endtask

    task automatic test_reset();
        int lat;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++;
        if ({in_ready, out_valid, alu_out} !== {1'b1, 1'b0, 32'h0}) begin
            n_fail++;
            $display("FAIL reset_initial: got in_ready=%b out_valid=%b alu_out=%h, want 1 0 0",
                     in_ready, out_valid, alu_out);
        end
        // Get a result with flags set, then reset asynchronously mid-cycle.
        do_op(c_add, 32'h7FFF_FFFF, 32'h1, lat);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({out_valid, alu_out, flag_z, flag_n, flag_c, flag_v} !== {1'b0, 32'h0, 4'b0000}) begin
            n_fail++;
            $display("FAIL reset_async: got out_valid=%b alu_out=%h zncv=%b, want 0 0 0000",
                     out_valid, alu_out, {flag_z, flag_n, flag_c, flag_v});
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release: got in_ready=%b, want 1", in_ready);
        end
    endtask

    task automatic test_single_ops();
        vec_t v[12];
        v[0]  = '{c_add,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 4'b0101, 8'd1};
        v[1]  = '{c_sub,  32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 4'b0110, 8'd1};
        v[2]  = '{c_add,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 4'b1010, 8'd1};
        v[3]  = '{c_sub,  32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 4'b0001, 8'd1};
        v[4]  = '{c_and,  32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234, 4'b0000, 8'd1};
        v[5]  = '{c_xnor, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 4'b0100, 8'd1};
        v[6]  = '{c_nor,  32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000, 4'b1000, 8'd1};
        v[7]  = '{c_sra,  32'h8000_0000, 32'h0000_0024, 32'hF800_0000, 4'b0100, 8'd1};
        v[8]  = '{c_sll,  32'h0000_0001, 32'h0000_001F, 32'h8000_0000, 4'b0100, 8'd1};
        v[9]  = '{c_srl,  32'h8000_0000, 32'h0000_0021, 32'h4000_0000, 4'b0000, 8'd1};
        v[10] = '{c_slt,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 4'b0000, 8'd1};
        v[11] = '{c_sltu, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 4'b1000, 8'd1};
        run_table("single", v, 12);
    endtask

    task automatic test_multicycle();
        vec_t v[6];
        v[0] = '{c_mul,  32'h0001_0003, 32'h0000_0005, 32'h0005_000F, 4'b0000, 8'd33};
        v[1] = '{c_mul,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 4'b0000, 8'd33};
        v[2] = '{c_divu, 32'd100,       32'd7,         32'd14,        4'b0000, 8'd33};
        v[3] = '{c_remu, 32'd100,       32'd7,         32'd2,         4'b0000, 8'd33};
        v[4] = '{c_divu, 32'h1234_5678, 32'h0,         32'hFFFF_FFFF, 4'b0100, 8'd33};
        v[5] = '{c_remu, 32'd9,         32'h0,         32'd9,         4'b0000, 8'd33};
        run_table("multi", v, 6);
    endtask

    task automatic test_back_to_back();
        int lat;
        do_op(c_slt, 32'hFFFF_FFFF, 32'h1, lat);
        n_checks++;
        if ({out_valid, alu_out} !== {1'b1, 32'h1} || lat != 1) begin
            n_fail++;
            $display("FAIL bp_slt: got valid=%b res=%h lat=%0d, want 1 00000001 1",
                     out_valid, alu_out, lat);
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if ({out_valid, in_ready, alu_out} !== {1'b1, 1'b0, 32'h1}) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: got valid=%b in_ready=%b res=%h, want 1 0 00000001",
                         i, out_valid, in_ready, alu_out);
            end
        end
        @(negedge clk);
        out_ready   = 1'b1;
        in_valid    = 1'b1;
        alu_control = c_sub;
        op1         = 32'd10;
        op2         = 32'd3;
        @(posedge clk);
        #1;
        n_checks++;
        if ({out_valid, alu_out} !== {1'b1, 32'd7}) begin
            n_fail++;
            $display("FAIL b2b_first: got valid=%b res=%h, want 1 00000007", out_valid, alu_out);
        end
        @(negedge clk);
        alu_control = c_add;
        op1         = 32'd1;
        op2         = 32'd1;
        @(posedge clk);
        #1;
        n_checks++;
        if ({out_valid, alu_out} !== {1'b1, 32'd2}) begin
            n_fail++;
            $display("FAIL b2b_second: got valid=%b res=%h, want 1 00000002", out_valid, alu_out);
        end
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL b2b_drain: got valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset_busy();
        int  lat;
        logic seen;
        @(negedge clk);
        alu_control = c_divu;
        op1         = 32'd100;
        op2         = 32'd7;
        in_valid    = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({out_valid, alu_out} !== {1'b0, 32'h0}) begin
            n_fail++;
            $display("FAIL busy_reset: got valid=%b res=%h, want 0 0", out_valid, alu_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen  = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_abandon: got out_valid seen=%b, want 0", seen);
        end
        do_op(c_mul, 32'd6, 32'd7, lat);
        n_checks++;
        if ({alu_out, flag_z, flag_n, flag_c, flag_v} !== {32'd42, 4'b0000} || lat != 33) begin
            n_fail++;
            $display("FAIL busy_next_mul: got res=%h zncv=%b lat=%0d, want 0000002a 0000 33",
                     alu_out, {flag_z, flag_n, flag_c, flag_v}, lat);
        end
        consume();
    endtask

    initial begin
        test_reset();
        test_single_ops();
        test_multicycle();
        test_back_to_back();
        test_reset_busy();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want test completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
